// File: rtl/i2s_rx_chan_arb.sv
// rtl/i2s_rx_chan_arb.sv - RX channel sequencer merging L/R CDC words into a tagged FIFO write stream
module i2s_rx_chan_arb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mono,
  input  logic             clear,
  input  logic [WIDTH-1:0] ch0_data,
  input  logic             ch0_valid,
  output logic             ch0_ack,
  input  logic [WIDTH-1:0] ch1_data,
  input  logic             ch1_valid,
  output logic             ch1_ack,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_wchan,
  output logic             fifo_wvalid,
  input  logic             fifo_wready,
  output logic             err_desync,
  output logic             err_stall,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {
    EXP_L = 1'b0,
    EXP_R = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
  logic             fifo_wchan_q, fifo_wchan_d;
  logic             fifo_wvalid_q, fifo_wvalid_d;
  logic             err_desync_q, err_desync_d;
  logic             err_stall_q, err_stall_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic slot_free;
  logic accept_l;
  logic accept_r;
  logic desync;
  logic drain0;
  logic drain1;
  logic stall;
  logic wr_fire;

  // Handshake decode: which word is taken, drained or blocked this cycle
  always_comb begin
    slot_free = ~fifo_wvalid_q | fifo_wready;
    wr_fire   = fifo_wvalid_q & fifo_wready;
    accept_l  = enable & (state_q == EXP_L) & ch0_valid & slot_free;
    accept_r  = enable & ~mono & (state_q == EXP_R) & ch1_valid & slot_free;
    // A fresh left word while still waiting for right means a lost right word
    desync    = enable & ~mono & (state_q == EXP_R) & ch0_valid & ~ch1_valid;
    // Channels not being forwarded are acked and discarded so the CDC never backs up
    drain0    = ~enable & ch0_valid;
    drain1    = (mono | ~enable) & ch1_valid;
    stall     = (enable & (state_q == EXP_L) & ch0_valid & ~slot_free)
              | (enable & ~mono & (state_q == EXP_R) & ch1_valid & ~slot_free);
    ch0_ack   = accept_l | drain0;
    ch1_ack   = accept_r | drain1;
  end

  // Next-state: L/R alternation, with disable and mono both pinning the sequence to L
  always_comb begin
    state_d = state_q;
    if (~enable || mono) begin
      state_d = EXP_L;
    end else begin
      case (state_q)
        EXP_L:   if (accept_l) state_d = EXP_R;
        EXP_R:   if (accept_r || desync) state_d = EXP_L;
        default: state_d = EXP_L;
      endcase
    end
  end

  // Output slot: load on accept, otherwise empty once the FIFO takes the word
  always_comb begin
    fifo_wdata_d  = fifo_wdata_q;
    fifo_wchan_d  = fifo_wchan_q;
    fifo_wvalid_d = fifo_wvalid_q;
    if (accept_l) begin
      fifo_wdata_d  = ch0_data;
      fifo_wchan_d  = 1'b0;
      fifo_wvalid_d = 1'b1;
    end else if (accept_r) begin
      fifo_wdata_d  = ch1_data;
      fifo_wchan_d  = 1'b1;
      fifo_wvalid_d = 1'b1;
    end else if (wr_fire) begin
      fifo_wvalid_d = 1'b0;
    end
  end

  // Sticky flags and write counter; a new event in the clear cycle survives the clear
  always_comb begin
    err_desync_d = desync | (err_desync_q & ~clear);
    err_stall_d  = stall | (err_stall_q & ~clear);
    if (clear) begin
      wr_count_d = wr_fire ? CNT_W'(1) : '0;
    end else begin
      wr_count_d = wr_fire ? wr_count_q + CNT_W'(1) : wr_count_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EXP_L;
      fifo_wdata_q  <= '0;
      fifo_wchan_q  <= 1'b0;
      fifo_wvalid_q <= 1'b0;
      err_desync_q  <= 1'b0;
      err_stall_q   <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      fifo_wdata_q  <= fifo_wdata_d;
      fifo_wchan_q  <= fifo_wchan_d;
      fifo_wvalid_q <= fifo_wvalid_d;
      err_desync_q  <= err_desync_d;
      err_stall_q   <= err_stall_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign fifo_wdata  = fifo_wdata_q;
  assign fifo_wchan  = fifo_wchan_q;
  assign fifo_wvalid = fifo_wvalid_q;
  assign err_desync  = err_desync_q;
  assign err_stall   = err_stall_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_i2s_rx_chan_arb.sv
// tb/tb_i2s_rx_chan_arb.sv - scoreboard bench for the RX channel sequencer
module tb_i2s_rx_chan_arb;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             mono;
  logic             clear;
  logic [WIDTH-1:0] ch0_data;
  logic             ch0_valid;
  logic             ch0_ack;
  logic [WIDTH-1:0] ch1_data;
  logic             ch1_valid;
  logic             ch1_ack;
  logic [WIDTH-1:0] fifo_wdata;
  logic             fifo_wchan;
  logic             fifo_wvalid;
  logic             fifo_wready;
  logic             err_desync;
  logic             err_stall;
  logic [CNT_W-1:0] wr_count;

  i2s_rx_chan_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mono        (mono),
    .clear       (clear),
    .ch0_data    (ch0_data),
    .ch0_valid   (ch0_valid),
    .ch0_ack     (ch0_ack),
    .ch1_data    (ch1_data),
    .ch1_valid   (ch1_valid),
    .ch1_ack     (ch1_ack),
    .fifo_wdata  (fifo_wdata),
    .fifo_wchan  (fifo_wchan),
    .fifo_wvalid (fifo_wvalid),
    .fifo_wready (fifo_wready),
    .err_desync  (err_desync),
    .err_stall   (err_stall),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] src0_q[$];
  logic [WIDTH-1:0] src1_q[$];
  logic             ack0_s = 1'b0;
  logic             ack1_s = 1'b0;
  int               ack0_n = 0;
  int               ack1_n = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  logic             hold_c = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic chan, input logic [WIDTH-1:0] d);
    exp_q.push_back({chan, d});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // Left CDC source: holds each word until the ack seen in the previous cycle
  initial begin
    ch0_valid = 1'b0;
    ch0_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ch0_valid && ack0_s) ch0_valid = 1'b0;
      if (!ch0_valid && src0_q.size() > 0) begin
        ch0_data  = src0_q.pop_front();
        ch0_valid = 1'b1;
      end
    end
  end

  // Right CDC source
  initial begin
    ch1_valid = 1'b0;
    ch1_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ch1_valid && ack1_s) ch1_valid = 1'b0;
      if (!ch1_valid && src1_q.size() > 0) begin
        ch1_data  = src1_q.pop_front();
        ch1_valid = 1'b1;
      end
    end
  end

  // Monitor: FIFO scoreboard, counter model, slot stability under backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_m  = '0;
        hold_v = 1'b0;
        ack0_s = 1'b0;
        ack1_s = 1'b0;
      end else begin
        ack0_s = ch0_ack;
        ack1_s = ch1_ack;
        if (ch0_ack) ack0_n++;
        if (ch1_ack) ack1_n++;
        check("wr_count", wr_count, cnt_m);
        if (hold_v) begin
          check("hold_valid", fifo_wvalid, 1);
          check("hold_data", fifo_wdata, hold_d);
          check("hold_chan", fifo_wchan, hold_c);
        end
        if (fifo_wvalid && fifo_wready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            check("wdata", fifo_wdata, e[WIDTH-1:0]);
            check("wchan", fifo_wchan, e[WIDTH]);
          end
        end
        if (clear) cnt_m = (fifo_wvalid && fifo_wready) ? CNT_W'(1) : '0;
        else if (fifo_wvalid && fifo_wready) cnt_m = cnt_m + CNT_W'(1);
        hold_v = fifo_wvalid & ~fifo_wready;
        hold_d = fifo_wdata;
        hold_c = fifo_wchan;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    bit seen;
    rst_n       = 1'b0;
    enable      = 1'b0;
    mono        = 1'b0;
    clear       = 1'b0;
    fifo_wready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ch0_ack", ch0_ack, 0);
    check("rst_ch1_ack", ch1_ack, 0);
    check("rst_wvalid", fifo_wvalid, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_wchan", fifo_wchan, 0);
    check("rst_desync", err_desync, 0);
    check("rst_stall", err_stall, 0);
    check("rst_count", wr_count, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Stereo basic
    enable = 1'b1;
    fifo_wready = 1'b1;
    a0 = ack0_n;
    a1 = ack1_n;
    push_exp(1'b0, 32'h11111111);
    push_exp(1'b1, 32'h22222222);
    src0_q.push_back(32'h11111111);
    src1_q.push_back(32'h22222222);
    tick(6);
    check("stereo_drained", exp_q.size(), 0);
    check("stereo_ack0", ack0_n - a0, 1);
    check("stereo_ack1", ack1_n - a1, 1);
    check("stereo_count", wr_count, 2);

    // Backpressure with L pending and slot full
    mono = 1'b1;
    fifo_wready = 1'b0;
    a0 = ack0_n;
    push_exp(1'b0, 32'hA0A0A0A0);
    push_exp(1'b0, 32'hC0C0C0C0);
    src0_q.push_back(32'hA0A0A0A0);
    src0_q.push_back(32'hC0C0C0C0);
    tick(2);
    tick(5);
    check("bp_ack_count", ack0_n - a0, 1);
    check("bp_stall", err_stall, 1);
    check("bp_wvalid", fifo_wvalid, 1);
    check("bp_wdata", fifo_wdata, 32'hA0A0A0A0);
    fifo_wready = 1'b1;
    @(negedge clk);
    check("bp_ack_on_release", ch0_ack, 1);
    tick(3);
    check("bp_drained", exp_q.size(), 0);
    check("bp_ack_total", ack0_n - a0, 2);
    pulse_clear();
    tick(1);
    check("clr_stall", err_stall, 0);
    check("clr_count", wr_count, 0);

    // Desync: two L words with no R between them
    mono = 1'b0;
    push_exp(1'b0, 32'h0000000A);
    push_exp(1'b0, 32'h0000000B);
    src0_q.push_back(32'h0000000A);
    src0_q.push_back(32'h0000000B);
    tick(6);
    check("desync_flag", err_desync, 1);
    check("desync_drained", exp_q.size(), 0);
    push_exp(1'b1, 32'h00000033);
    src1_q.push_back(32'h00000033);
    tick(4);
    check("desync_then_r", exp_q.size(), 0);

    // Mono: only ch0 forwarded, ch1 drained
    pulse_clear();
    mono = 1'b1;
    a0 = ack0_n;
    a1 = ack1_n;
    push_exp(1'b0, 32'h00000001);
    push_exp(1'b0, 32'h00000002);
    src0_q.push_back(32'h00000001);
    src0_q.push_back(32'h00000002);
    src1_q.push_back(32'h00000009);
    src1_q.push_back(32'h00000009);
    tick(8);
    check("mono_drained", exp_q.size(), 0);
    check("mono_ack0", ack0_n - a0, 2);
    check("mono_ack1", ack1_n - a1, 2);
    check("mono_desync", err_desync, 0);
    check("mono_stall", err_stall, 0);

    // Disable: both channels drained, nothing written
    pulse_clear();
    mono = 1'b0;
    enable = 1'b0;
    a0 = ack0_n;
    a1 = ack1_n;
    src0_q.push_back(32'h00000005);
    src0_q.push_back(32'h00000006);
    src1_q.push_back(32'h00000007);
    src1_q.push_back(32'h00000008);
    tick(8);
    check("dis_ack0", ack0_n - a0, 2);
    check("dis_ack1", ack1_n - a1, 2);
    check("dis_count", wr_count, 0);
    check("dis_wvalid", fifo_wvalid, 0);

    // Clear coincident with a fresh desync: set wins
    enable = 1'b1;
    push_exp(1'b0, 32'h0000C0DE);
    push_exp(1'b0, 32'h0000BEEF);
    src0_q.push_back(32'h0000C0DE);
    src0_q.push_back(32'h0000BEEF);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ch0_ack) seen = 1'b1;
    end
    check("clr_wait_ack", seen, 1);
    @(posedge clk);
    #2;
    clear = 1'b1;
    @(posedge clk);
    #2;
    clear = 1'b0;
    check("clr_desync_set_wins", err_desync, 1);
    tick(4);
    check("clr_drained", exp_q.size(), 0);

    // Counter wrap with a 4-bit counter
    mono = 1'b1;
    pulse_clear();
    for (int i = 0; i < 17; i++) begin
      push_exp(1'b0, 32'h1000 + i);
      src0_q.push_back(32'h1000 + i);
    end
    tick(25);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_count", wr_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
